// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_op_e        : MDU operation encoding carried on md_op
//   md_state_e     : sequencer state
//   MD_*_CYCLES    : default fixed latencies of the MDU
//   md_is_arith()  : true for operations that occupy the MDU for several cycles
package md_scheduler_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  function automatic logic md_is_arith(input md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_scheduler_compute.sv
// md_compute: purely combinational 64-bit multiply / 32-bit divide.
//   op       in  operation (only mult/multu/div/divu produce a result)
//   a, b     in  forwarded $rs / $rt
//   hi_p     out pending HI (product high word or remainder)
//   lo_p     out pending LO (product low word or quotient)
//   div_zero out divisor is zero; the result must not be committed
module md_compute
  import md_scheduler_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_p,
  output logic [31:0] lo_p,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;

  // One unsigned divider serves both div and divu; signed division works on
  // magnitudes and fixes signs afterwards. 0x80000000 / -1 falls out as
  // magnitude 0x80000000 / 1 with equal signs, giving lo=0x80000000, hi=0.
  // A zero divisor is replaced by 1 so the divider never sees x/0.
  assign dvd = (op == MD_DIV) ? abs_a : a;
  assign dvs = (b == '0) ? 32'd1 : ((op == MD_DIV) ? abs_b : b);
  assign uq  = dvd / dvs;
  assign ur  = dvd % dvs;

  assign div_zero = (b == '0);

  always_comb begin
    hi_p = '0;
    lo_p = '0;
    unique case (op)
      MD_MULT:  {hi_p, lo_p} = prod_s;
      MD_MULTU: {hi_p, lo_p} = prod_u;
      MD_DIV: begin
        lo_p = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
        hi_p = a[31] ? (~ur + 32'd1) : ur;
      end
      MD_DIVU: begin
        lo_p = uq;
        hi_p = ur;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: multiply/divide sequencer beside the E-stage ALU.
// Owns HI/LO, models the fixed MDU latency with a down-counter and raises
// the D-stage stall while an MDU instruction would collide with one in flight.
//   clk, reset    system clock; synchronous active-high reset
//   start, md_op  E-stage MDU launch and its operation
//   src_a, src_b  forwarded $rs / $rt
//   d_is_md       D-stage instruction uses the MDU or HI/LO
//   hi, lo        architectural HI/LO (registered)
//   busy          operation in flight (registered)
//   stall         freeze F/D, bubble into E (combinational)
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  md_op_e        op;
  md_state_e     state;
  md_state_e     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          launch;
  logic          commit;
  logic [31:0]   c_hi;
  logic [31:0]   c_lo;
  logic          c_dz;
  logic [31:0]   hi_p;
  logic [31:0]   lo_p;
  logic          dz_p;

  assign op = md_op_e'(md_op);

  md_compute u_compute (
    .op       (op),
    .a        (src_a),
    .b        (src_b),
    .hi_p     (c_hi),
    .lo_p     (c_lo),
    .div_zero (c_dz)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    launch  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && md_is_arith(op)) begin
          launch  = 1'b1;
          state_n = S_BUSY;
          cnt_n   = (op inside {MD_MULT, MD_MULTU}) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      S_BUSY: begin
        // start is ignored here; the in-flight operation runs to completion.
        cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          commit  = 1'b1;
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      hi_p  <= '0;
      lo_p  <= '0;
      dz_p  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (launch) begin
        hi_p <= c_hi;
        lo_p <= c_lo;
        dz_p <= c_dz;
      end
      if (commit && !dz_p) begin
        hi <= hi_p;
        lo <= lo_p;
      end
      if (state == S_IDLE && start && op == MD_MTHI) hi <= src_a;
      if (state == S_IDLE && start && op == MD_MTLO) lo <= src_a;
    end
  end

  assign busy  = (state == S_BUSY);
  assign stall = d_is_md & (busy | (start & md_is_arith(op)));

endmodule

// File: tb/tb_md_scheduler.sv
module tb_md_scheduler;

  typedef longint unsigned u64_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        d_is_md = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        sb[$];
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  always #5 clk = ~clk;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .src_a   (src_a),
    .src_b   (src_b),
    .d_is_md (d_is_md),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall)
  );

  // Reference behaviour of the architectural HI/LO after an operation.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    int     sa;
    int     sbv;
    longint ps;
    u64_t   pu;
    sa  = a;
    sbv = b;
    case (op)
      3'd1: begin ps = longint'(sa) * longint'(sbv); h = ps[63:32]; l = ps[31:0]; end
      3'd2: begin pu = u64_t'(a) * u64_t'(b); h = pu[63:32]; l = pu[31:0]; end
      3'd3: begin
        if (b != 0) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = 32'h80000000; h = 0; end
          else begin l = sa / sbv; h = sa % sbv; end
        end
      end
      3'd4: if (b != 0) begin l = a / b; h = a % b; end
      3'd5: h = a;
      3'd6: l = a;
      default: ;
    endcase
  endfunction

  // Drive one launch in the current cycle, push its expected outcome, and
  // return at #1 after the launch edge (cycle t+1). st is stall in cycle t.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic st);
    exp_t e;
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    #1 st = stall;
    model(op, a, b, cur_hi, cur_lo);
    e.hi = cur_hi;
    e.lo = cur_lo;
    e.cycles = (op == 3'd1 || op == 3'd2) ? 5 : ((op == 3'd3 || op == 3'd4) ? 10 : 0);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
  endtask

  // Count busy cycles from now until busy drops, bounded.
  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; d_is_md = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    d_is_md = 1'b0;
  endtask

  task automatic test_arith(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    exp_t e; int unsigned cyc; logic st;
    launch(op, a, b, st);
    wait_done(cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.cycles) begin n_bad++; $display("FAIL %s_cycles: got %0d want %0d", name, cyc, e.cycles); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL %s_hi: got %h want %h", name, hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL %s_lo: got %h want %h", name, lo, e.lo); end
  endtask

  task automatic test_mtlo_mthi();
    exp_t e; logic st;
    launch(3'd6, 32'hCAFE0000, 32'h0, st);
    e = sb.pop_front();
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL mtlo_lo: got %h want %h", lo, e.lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    launch(3'd5, 32'h00001234, 32'h0, st);
    e = sb.pop_front();
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL mthi_hi: got %h want %h", hi, e.hi); end
    launch(3'd6, 32'h00005678, 32'h0, st);
    e = sb.pop_front();
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL mtlo2_lo: got %h want %h", lo, e.lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mtlo2_busy: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    exp_t e; int unsigned cyc; logic st;
    d_is_md = 1'b1;
    launch(3'd3, 32'd100, 32'd7, st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL stall_launch: got %b want 1", st); end
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_busy%0d: got %b want 1", cyc, stall); end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.cycles) begin n_bad++; $display("FAIL stall_cycles: got %0d want %0d", cyc, e.cycles); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_after: got %b want 0", stall); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL stall_div_lo: got %h want %h", lo, e.lo); end
    d_is_md = 1'b0;
    launch(3'd1, 32'd9, 32'd9, st);
    n_cmp++; if (st !== 1'b0) begin n_bad++; $display("FAIL nostall_launch: got %b want 0", st); end
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nostall_busy%0d: got %b want 0", cyc, stall); end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.cycles) begin n_bad++; $display("FAIL nostall_cycles: got %0d want %0d", cyc, e.cycles); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL nostall_lo: got %h want %h", lo, e.lo); end
  endtask

  task automatic test_reset_busy();
    int unsigned cyc; logic st; exp_t e;
    launch(3'd1, 32'h00012345, 32'h00054321, st);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    e = sb.pop_front();
    cur_hi = '0; cur_lo = '0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstbusy_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstbusy_hi: got %h want 00000000", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rstbusy_lo: got %h want 00000000", lo); end
    repeat (8) @(posedge clk);
    #1;
    wait_done(cyc);
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rstbusy_late_lo: got %h want 00000000 (abandoned %h)", lo, e.lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstbusy_late_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int unsigned cyc; logic st;
    launch(3'd2, 32'h89ABCDEF, 32'h00010001, st);
    // Stray launch while busy must be ignored.
    @(negedge clk);
    start = 1'b1; md_op = 3'd3; src_a = 32'd50; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    wait_done(cyc);
    cyc++;
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.cycles) begin n_bad++; $display("FAIL b2b_ignore_cycles: got %0d want %0d", cyc, e.cycles); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL b2b_ignore_hi: got %h want %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL b2b_ignore_lo: got %h want %h", lo, e.lo); end
    // Relaunch in the same cycle busy drops.
    launch(3'd4, 32'd1000, 32'd33, st);
    wait_done(cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.cycles) begin n_bad++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, e.cycles); end
    n_cmp++; if (hi !== e.hi) begin n_bad++; $display("FAIL b2b_hi: got %h want %h", hi, e.hi); end
    n_cmp++; if (lo !== e.lo) begin n_bad++; $display("FAIL b2b_lo: got %h want %h", lo, e.lo); end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a; logic [31:0] b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      test_arith("rand", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_arith("mult", 3'd1, 32'hFFFFFFFD, 32'd5);
    test_arith("multu", 3'd2, 32'hFFFFFFFF, 32'd2);
    test_arith("div", 3'd3, 32'hFFFFFFF9, 32'd2);
    test_mtlo_mthi();
    test_arith("divu_zero", 3'd4, 32'd7, 32'd0);
    test_arith("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
    test_arith("div_negdvs", 3'd3, 32'd7, 32'hFFFFFFFE);
    test_stall();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multiply/divide sequencer for the pipelined MIPS core. It sits beside the ALU in the E stage and accepts mult/multu/div/divu/mthi/mtlo from the E-stage decode. It owns the architectural HI/LO registers and models the fixed multi-cycle latency of the MDU with a busy counter. It drives the D-stage stall request that keeps any MDU instruction out of E while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is a valid MDU launch this cycle
- md_op  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- src_a  in  32  forwarded [$rs]
- src_b  in  32  forwarded [$rt]
- d_is_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  operation in flight
- stall  out  1  freeze F/D, bubble into E

## Operation
- States: IDLE, BUSY; down-counter cnt, width clog2(DIV_CYCLES+1).
- IDLE with start=1:
  - mult/multu/div/divu: compute result from src_a/src_b into pending hi_p/lo_p, load cnt with MULT_CYCLES or DIV_CYCLES, go BUSY.
  - mthi/mtlo: write src_a to hi/lo at this edge; no busy, stay IDLE.
  - md_op 0 or 7: no action.
- Arithmetic:
  - mult: signed 64-bit product, {hi,lo}.
  - multu: unsigned 64-bit product, {hi,lo}.
  - div: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Division by zero: hi/lo stay unchanged at commit; busy timing is unaffected.
  - 0x80000000 / -1 (div): lo = 0x80000000, hi = 0.
- BUSY: cnt decrements each cycle. On the edge where cnt goes 1→0, commit hi_p/lo_p to hi/lo and return to IDLE.
- start while BUSY cannot occur because stall prevents it. If it is asserted anyway, it is ignored and the in-flight operation is unaffected.
- stall = d_is_md & (busy | (start & md_op∈{1..4})), combinational.
- reset: hi=0, lo=0, busy=0, cnt=0, state IDLE, pending registers cleared. Reset during BUSY aborts the operation with no later commit.

## Timing
- start sampled at rising edge E (cycle t). busy=1 in cycles t+1 .. t+N, N = MULT_CYCLES or DIV_CYCLES.
- New hi/lo become visible in cycle t+N+1, the same cycle busy drops. mfhi/mflo reaching E in t+N+1 reads the new values.
- mthi/mtlo: the value is visible in cycle t+1.
- stall is asserted in cycle t (launch cycle) and in every busy cycle when d_is_md=1. It is deasserted in cycle t+N+1.
- busy, hi, lo are registered; stall is the only combinational output.

## Structure
- Op encodings MD_NONE..MD_MTLO and the default latencies go in the shared param.v as `define constants, next to ALU*/NPC*.
- One natural sub-module, md_compute: purely combinational 64-bit multiply/divide producing {hi_p, lo_p} and a div-by-zero flag.
- The state register, counter and HI/LO registers stay in md_scheduler.

## Test plan
- mult, src_a=0xFFFFFFFD (−3), src_b=5 → busy exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu, 0xFFFFFFFF × 2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div, −7 / 2 → busy exactly 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, 7 / 0 with prior hi=0x1234, lo=0x5678 → busy 10 cycles; hi/lo unchanged.
- mtlo src_a=0xCAFE0000 → lo=0xCAFE0000 next cycle, busy never asserted.
- Stall: start div, then hold d_is_md=1 → stall=1 in launch cycle plus 10 busy cycles, 0 in cycle t+11. With d_is_md=0 throughout, stall stays 0.
- Reset during busy: reset in busy cycle 3 of a mult → busy=0, hi=lo=0 next cycle, no later commit.
